// File: rtl/bayer_quad_demosaic_pkg.sv
// Shared constants for the Bayer quad demosaic: sample width, quad layouts
// and the raw/output frame geometry.
package bayer_quad_demosaic_pkg;

  localparam int PIX_W_DEF = 12;

  localparam int BAYER_GRBG = 0;
  localparam int BAYER_RGGB = 1;
  localparam int BAYER_BGGR = 2;
  localparam int BAYER_GBRG = 3;

  localparam int RAW_WIDTH  = 1600;
  localparam int RAW_HEIGHT = 960;
  localparam int OUT_WIDTH  = 800;
  localparam int OUT_HEIGHT = 480;

endpackage

// File: rtl/bayer_quad_demosaic_if.sv
// Raw Bayer stream in, quad RGB stream out. The master side is the capture
// front end plus the downstream consumer; the slave side is the demosaic.
interface bayer_quad_demosaic_if
  import bayer_quad_demosaic_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic [PIX_W-1:0] iData;
  logic             iDVAL;
  logic             iFval;
  logic [15:0]      iX_Cont;
  logic [15:0]      iY_Cont;

  logic [PIX_W-1:0] oRed;
  logic [PIX_W-1:0] oGreen;
  logic [PIX_W-1:0] oBlue;
  logic             oDVAL;
  logic             oFval;
  logic [15:0]      oX_Cont;
  logic [15:0]      oY_Cont;

  modport master (
    output iData, iDVAL, iFval, iX_Cont, iY_Cont,
    input  oRed, oGreen, oBlue, oDVAL, oFval, oX_Cont, oY_Cont
  );

  modport slave (
    input  iData, iDVAL, iFval, iX_Cont, iY_Cont,
    output oRed, oGreen, oBlue, oDVAL, oFval, oX_Cont, oY_Cont
  );
endinterface

// File: rtl/bayer_line_ram.sv
// Line buffer holding the even-row sample pairs of one Bayer line.
// Simple dual-port: one write port, one registered read port.
module bayer_line_ram #(
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so this maps onto block RAM;
  // a reset would force it into flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bayer_quad_demosaic.sv
// Collapses each 2x2 Bayer quad into one RGB pixel: even-row pairs are parked
// in a line buffer and merged with the matching odd-row pair two edges later.
module bayer_quad_demosaic
  import bayer_quad_demosaic_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int RAW_W = RAW_WIDTH,
  parameter int BAYER = BAYER_GRBG
) (
  input logic                  CCD_PIXCLK,
  input logic                  iRst_n,
  bayer_quad_demosaic_if.slave bus
);
  localparam int DEPTH  = RAW_W / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAIR_W = 2 * PIX_W;
  localparam logic [15:0] X_LIMIT = 16'(RAW_W);

  logic              accept;
  logic              pair_done;
  logic              quad_done;
  logic [ADDR_W-1:0] col_addr;

  logic [PIX_W-1:0]  hold_e;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PAIR_W-1:0] wr_data;
  logic [PAIR_W-1:0] rd_pair;

  logic              s1_valid;
  logic [PAIR_W-1:0] s1_pair;
  logic [15:0]       s1_x;
  logic [15:0]       s1_y;

  logic [1:0]        fval_d;
  logic [PIX_W-1:0]  red_q, green_q, blue_q;
  logic              dval_q;
  logic [15:0]       x_q, y_q;

  logic [PIX_W-1:0]  p00, p01, p10, p11;
  logic [PIX_W-1:0]  red, blue, g1, g2;
  logic [PIX_W:0]    green_sum;

  assign accept    = bus.iDVAL && bus.iFval && (bus.iX_Cont < X_LIMIT);
  assign pair_done = accept && bus.iX_Cont[0] && !bus.iY_Cont[0];
  assign quad_done = accept && bus.iX_Cont[0] && bus.iY_Cont[0];
  assign col_addr  = bus.iX_Cont[ADDR_W:1];

  // Writes happen only on even rows and reads only on odd rows, so the two
  // ports never collide on one address.
  bayer_line_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PAIR_W)
  ) u_line_ram (
    .clk     (CCD_PIXCLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (quad_done),
    .rd_addr (col_addr),
    .rd_data (rd_pair)
  );

  assign {p00, p01} = rd_pair;
  assign {p10, p11} = s1_pair;

  always_comb begin
    // NOTE: every output gets a default before the case, so no latch can be
    // inferred for a layout the case does not list.
    red  = p01;
    blue = p10;
    g1   = p00;
    g2   = p11;
    case (BAYER)
      BAYER_RGGB: begin red  = p00; g1 = p01; g2 = p10; blue = p11; end
      BAYER_BGGR: begin blue = p00; g1 = p01; g2 = p10; red  = p11; end
      BAYER_GBRG: begin g1 = p00; blue = p01; red = p10; g2 = p11; end
      default: ;
    endcase
    // One extra bit keeps the sum exact; the shift truncates without rounding.
    green_sum = {1'b0, g1} + {1'b0, g2};
  end

  // NOTE: state updates use nonblocking assignments so every register samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      hold_e   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      s1_valid <= 1'b0;
      s1_pair  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      fval_d   <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      dval_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      // E survives iDVAL gaps; a stray odd sample simply reuses it.
      if (accept && !bus.iX_Cont[0]) hold_e <= bus.iData;

      wr_en <= pair_done;
      if (pair_done) begin
        wr_addr <= col_addr;
        wr_data <= {hold_e, bus.iData};
      end

      // Any cycle without a completed quad, including iFval low, drops stage 1.
      s1_valid <= quad_done;
      if (quad_done) begin
        s1_pair <= {hold_e, bus.iData};
        s1_x    <= {1'b0, bus.iX_Cont[15:1]};
        s1_y    <= {1'b0, bus.iY_Cont[15:1]};
      end

      fval_d <= {fval_d[0], bus.iFval};

      dval_q <= s1_valid;
      if (s1_valid) begin
        red_q   <= red;
        green_q <= PIX_W'(green_sum >> 1);
        blue_q  <= blue;
        x_q     <= s1_x;
        y_q     <= s1_y;
      end
    end
  end

  assign bus.oRed    = red_q;
  assign bus.oGreen  = green_q;
  assign bus.oBlue   = blue_q;
  assign bus.oDVAL   = dval_q;
  assign bus.oFval   = fval_d[1];
  assign bus.oX_Cont = x_q;
  assign bus.oY_Cont = y_q;

endmodule
